// File: rtl/vga_line_pattern_gen.sv
// Per-line RGB565 test-pattern writer for the VGA line buffer: N_BARS colour bars then black padding.
// Optional horizontal gradient for mode 3 when VGA_PAT_GRADIENT_EN is defined.
module vga_line_pattern_gen #(
  parameter int unsigned H_ACTIVE = 512,
  parameter int unsigned N_BARS   = 4,
  parameter int unsigned BAR_W    = 80,
  parameter int unsigned V_FILL   = 240,
  parameter int unsigned BAND_H   = 120,
  parameter int unsigned CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tag_update,
  input  logic [CNT_W-1:0] i_tag_line,
  input  logic [1:0]       i_mode,
  output logic             o_en,
  output logic [15:0]      o_data,
  output logic             o_busy,
  output logic             o_line_done,
  output logic             o_overrun
);

  localparam int unsigned BAR_TOT = N_BARS * BAR_W;
  localparam int unsigned PAD_W   = H_ACTIVE - BAR_TOT;
  localparam int unsigned N_BND   = (V_FILL - 1) / BAND_H;

  typedef enum logic [1:0] {IDLE, BARS, PAD, DONE} state_t;

  state_t             state, state_d;
  logic               sync1, sync2, prev;
  logic [CNT_W-1:0]   line_s1, line_s2;
  logic [CNT_W-1:0]   x, x_d, sub, sub_d, pc, pc_d;
  logic [2:0]         j, j_d;
  logic [1:0]         mode_q, mode_d;
  logic               odd_q, odd_d, odd_c, req;
  logic               en_d, busy_d, done_d, ovr_d;
  logic [15:0]        data_d;

  function automatic logic [15:0] pal(input logic [2:0] p);
    case (p)
      3'd0:    return 16'hF800;
      3'd1:    return 16'h001F;
      3'd2:    return 16'hF81F;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'hFFE0;
      3'd5:    return 16'h07FF;
      3'd6:    return 16'hFFFF;
      default: return 16'h8410;
    endcase
  endfunction

  function automatic logic [15:0] colour(input logic [2:0] jj, input logic [1:0] m, input logic odd);
    logic rev;
    rev = (m == 2'd1) || ((m == 2'd2) && odd);
    return pal(rev ? (3'(N_BARS - 1) - jj) : jj);
  endfunction

`ifdef VGA_PAT_GRADIENT_EN
  function automatic logic [15:0] grad(input logic [CNT_W-1:0] xx);
    logic [15:0] xe;
    xe = 16'(xx);
    return {xe[8:4], 6'd0, ~xe[8:4]};
  endfunction
`endif

  // Two-flop request/line synchroniser with rising-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      prev    <= 1'b0;
      line_s1 <= '0;
      line_s2 <= '0;
    end else begin
      sync1   <= i_tag_update;
      sync2   <= sync1;
      prev    <= sync2;
      line_s1 <= i_tag_line;
      line_s2 <= line_s1;
    end
  end

  assign req = sync2 & ~prev;

  // Band parity: count how many multiples of BAND_H the line has passed
  always_comb begin
    odd_c = 1'b0;
    for (int unsigned k = 1; k <= N_BND; k++) begin
      odd_c = odd_c ^ (32'(line_s2) >= k * BAND_H);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      x           <= '0;
      sub         <= '0;
      pc          <= '0;
      j           <= '0;
      mode_q      <= '0;
      odd_q       <= 1'b0;
      o_en        <= 1'b0;
      o_data      <= '0;
      o_busy      <= 1'b0;
      o_line_done <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      state       <= state_d;
      x           <= x_d;
      sub         <= sub_d;
      pc          <= pc_d;
      j           <= j_d;
      mode_q      <= mode_d;
      odd_q       <= odd_d;
      o_en        <= en_d;
      o_data      <= data_d;
      o_busy      <= busy_d;
      o_line_done <= done_d;
      o_overrun   <= ovr_d;
    end
  end

  // Next state and next registered outputs; the word computed here appears on o_data next edge
  always_comb begin
    state_d = state;
    x_d     = x;
    sub_d   = sub;
    pc_d    = pc;
    j_d     = j;
    mode_d  = mode_q;
    odd_d   = odd_q;
    en_d    = 1'b0;
    data_d  = '0;
    busy_d  = o_busy;
    done_d  = 1'b0;
    ovr_d   = 1'b0;
    case (state)
      IDLE: begin
        if (req && (32'(line_s2) < V_FILL)) begin
          state_d = BARS;
          x_d     = '0;
          sub_d   = '0;
          j_d     = '0;
          mode_d  = i_mode;
          odd_d   = odd_c;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          data_d  = colour(3'd0, i_mode, odd_c);
`ifdef VGA_PAT_GRADIENT_EN
          if (i_mode == 2'd3) data_d = grad('0);
`endif
        end
      end
      BARS: begin
        ovr_d = req;
        if (x == CNT_W'(BAR_TOT - 1)) begin
          if (PAD_W == 0) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = PAD;
            pc_d    = '0;
            en_d    = 1'b1;
          end
        end else begin
          x_d = x + CNT_W'(1);
          if (sub == CNT_W'(BAR_W - 1)) begin
            sub_d = '0;
            j_d   = j + 3'd1;
          end else begin
            sub_d = sub + CNT_W'(1);
          end
          en_d   = 1'b1;
          data_d = colour(j_d, mode_q, odd_q);
`ifdef VGA_PAT_GRADIENT_EN
          if (mode_q == 2'd3) data_d = grad(x_d);
`endif
        end
      end
      PAD: begin
        ovr_d = req;
        if (pc == CNT_W'(PAD_W - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          pc_d = pc + CNT_W'(1);
          en_d = 1'b1;
        end
      end
      DONE: begin
        ovr_d   = req;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vga_line_pattern_gen.sv
// Directed bench for vga_line_pattern_gen: default 4-bar instance and an 8x64 no-padding instance.
module tb_vga_line_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tag_update;
  logic [9:0]  tag_line;
  logic [1:0]  mode;
  logic        a_en, a_busy, a_done, a_ovr;
  logic [15:0] a_data;
  logic        b_en, b_busy, b_done, b_ovr;
  logic [15:0] b_data;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] wa [512];
  logic [15:0] wb [512];

  always #5 clk = ~clk;

  vga_line_pattern_gen dut_a (
    .clk(clk), .rst_n(rst_n), .i_tag_update(tag_update), .i_tag_line(tag_line), .i_mode(mode),
    .o_en(a_en), .o_data(a_data), .o_busy(a_busy), .o_line_done(a_done), .o_overrun(a_ovr)
  );

  vga_line_pattern_gen #(.N_BARS(8), .BAR_W(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_tag_update(tag_update), .i_tag_line(tag_line), .i_mode(mode),
    .o_en(b_en), .o_data(b_data), .o_busy(b_busy), .o_line_done(b_done), .o_overrun(b_ovr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] pal(input int p);
    case (p)
      0: return 16'hF800;
      1: return 16'h001F;
      2: return 16'hF81F;
      3: return 16'h07E0;
      4: return 16'hFFE0;
      5: return 16'h07FF;
      6: return 16'hFFFF;
      default: return 16'h8410;
    endcase
  endfunction

  function automatic logic [15:0] exp_word(input int nb, input int bw, input int x, input int m, input int line);
    int jj;
    bit rev;
    logic [15:0] xv;
    if (x >= nb * bw) return 16'h0000;
    jj  = x / bw;
    rev = (m == 1) || (m == 2 && ((line / 120) % 2 == 1));
    xv  = 16'(x);
`ifdef VGA_PAT_GRADIENT_EN
    if (m == 3) return {xv[8:4], 6'd0, ~xv[8:4]};
`endif
    return pal(rev ? nb - 1 - jj : jj);
  endfunction

  // One request; captures both instances' words and checks count, data, done and overrun
  task automatic run_line(input int line, input int m, input int ovr_at, input int rst_at, input bit expect_line);
    int na = 0, nb = 0, nd = 0, no = 0;
    bit aborted = 0;
    for (int i = 0; i < 512; i++) begin
      wa[i] = 'x;
      wb[i] = 'x;
    end
    tag_line   = 10'(line);
    mode       = 2'(m);
    tag_update = 1'b1;
    for (int c = 1; c <= 560; c++) begin
      @(negedge clk);
      if (c == 2) chk($sformatf("pre_latency_l%0d", line), 32'(a_en), 32'd0);
      if (c == 3) chk($sformatf("latency_l%0d", line), 32'(a_en), 32'(expect_line));
      if (c == 10) mode = 2'(m + 1);
      if (ovr_at > 0 && c == ovr_at) tag_update = 1'b0;
      if (ovr_at > 0 && c == ovr_at + 4) tag_update = 1'b1;
      if (a_en) begin
        if (na < 512) wa[na] = a_data;
        chk($sformatf("a_word_l%0d_x%0d", line, na), 32'(a_data), 32'(exp_word(4, 80, na, m, line)));
        na++;
      end
      if (b_en) begin
        if (nb < 512) wb[nb] = b_data;
        chk($sformatf("b_word_l%0d_x%0d", line, nb), 32'(b_data), 32'(exp_word(8, 64, nb, m, line)));
        nb++;
      end
      if (a_done) nd++;
      if (a_ovr) no++;
      if (rst_at > 0 && na == rst_at) begin
        rst_n = 1'b0;
        tag_update = 1'b0;
        #1;
        chk("rst_mid_en", 32'(a_en), 32'd0);
        chk("rst_mid_busy", 32'(a_busy), 32'd0);
        chk("rst_mid_b_en", 32'(b_en), 32'd0);
        aborted = 1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      chk($sformatf("a_count_l%0d", line), 32'(na), expect_line ? 32'd512 : 32'd0);
      chk($sformatf("b_count_l%0d", line), 32'(nb), expect_line ? 32'd512 : 32'd0);
      chk($sformatf("done_l%0d", line), 32'(nd), 32'(expect_line));
      chk($sformatf("overrun_l%0d", line), 32'(no), (ovr_at > 0) ? 32'd1 : 32'd0);
      chk($sformatf("idle_busy_l%0d", line), 32'(a_busy), 32'd0);
    end
    tag_update = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    tag_update = 1'b0;
    tag_line   = '0;
    mode       = '0;
    repeat (3) @(negedge clk);
    chk("reset_en",   32'(a_en),   32'd0);
    chk("reset_data", 32'(a_data), 32'd0);
    chk("reset_busy", 32'(a_busy), 32'd0);
    chk("reset_done", 32'(a_done), 32'd0);
    chk("reset_ovr",  32'(a_ovr),  32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_line(5, 0, 0, 0, 1);
    chk("m0_x0",   32'(wa[0]),   32'h0000F800);
    chk("m0_x80",  32'(wa[80]),  32'h0000001F);
    chk("m0_x160", 32'(wa[160]), 32'h0000F81F);
    chk("m0_x319", 32'(wa[319]), 32'h000007E0);
    chk("m0_x320", 32'(wa[320]), 32'h00000000);
    chk("b_m0_x511", 32'(wb[511]), 32'h00008410);

    run_line(130, 2, 0, 0, 1);
    chk("m2_l130_x0",   32'(wa[0]),   32'h000007E0);
    chk("m2_l130_x240", 32'(wa[240]), 32'h0000F800);
    chk("b_m2_l130_x0", 32'(wb[0]),   32'h00008410);

    run_line(119, 2, 0, 0, 1);
    chk("m2_l119_x0",  32'(wa[0]),  32'h0000F800);
    chk("m2_l119_x80", 32'(wa[80]), 32'h0000001F);

    run_line(240, 0, 0, 0, 0);
    run_line(479, 1, 0, 0, 0);

    run_line(7, 1, 100, 0, 1);
    chk("m1_x0",       32'(wa[0]),   32'h000007E0);
    chk("b_m1_x511",   32'(wb[511]), 32'h0000F800);

    run_line(9, 0, 0, 200, 1);
    run_line(10, 0, 0, 0, 1);
    chk("post_rst_x0", 32'(wa[0]), 32'h0000F800);

    run_line(20, 3, 0, 0, 1);
`ifdef VGA_PAT_GRADIENT_EN
    chk("m3_x16", 32'(wa[16]), 32'h0000081E);
`else
    chk("m3_x16", 32'(wa[16]), 32'h0000F800);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
